fir_output_decimator: RTL and testbench

Downstream stage of the FIR filter. Consumes the filter's 16-bit signed output stream and decimates it by DEC using accumulate-and-dump. Each DEC-sample sum is rounded, right-shifted and saturated to OUT_W bits. Results are buffered in a small first-word-fall-through (FWFT) FIFO and presented on a valid/ready interface to the next block.

---
 rtl/fir_output_decimator_if.sv | 21 ++
 rtl/fir_output_decimator.sv | 123 ++++++++++++
 tb/tb_fir_output_decimator.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/fir_output_decimator_if.sv
// Stream bundle for the FIR output decimator: input sample stream plus
// the valid/ready result stream toward the next block.
interface fir_output_decimator_if #(
    parameter int OUT_W = 8
);
    logic                    in_valid;
    logic signed [15:0]      in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/fir_output_decimator.sv
// Accumulate-and-dump decimator: DEC valid samples are summed, rounded,
// shifted and saturated to OUT_W bits, then queued in a small FWFT FIFO.
module fir_output_decimator #(
    parameter int DEC   = 4,
    parameter int SHIFT = 2,
    parameter int OUT_W = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    fir_output_decimator_if.slave    bus,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic                     sat_event,
    input  logic                     clr_ovf
);
    localparam int AW = 16 + $clog2(DEC) + 1;
    localparam int CW = (DEC > 1) ? $clog2(DEC) : 1;
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    localparam logic signed [AW:0]   BIAS = (AW+1)'((SHIFT > 0) ? (2 ** (SHIFT - 1)) : 0);
    localparam logic signed [AW-1:0] MAXV = AW'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [AW-1:0] MINV = AW'(-(2 ** (OUT_W - 1)));

    function automatic logic signed [AW-1:0] round_shift(input logic signed [AW-1:0] s);
        logic signed [AW:0] t;
        t = {s[AW-1], s} + BIAS;
        t = t >>> SHIFT;
        return t[AW-1:0];
    endfunction

    function automatic logic is_sat(input logic signed [AW-1:0] r);
        return (r > MAXV) || (r < MINV);
    endfunction

    function automatic logic signed [OUT_W-1:0] sat_clip(input logic signed [AW-1:0] r);
        if (r > MAXV)
            return MAXV[OUT_W-1:0];
        else if (r < MINV)
            return MINV[OUT_W-1:0];
        else
            return r[OUT_W-1:0];
    endfunction

    logic [CW-1:0]            cnt;
    logic signed [AW-1:0]     acc;
    logic signed [AW-1:0]     sum_p0;
    logic signed [AW-1:0]     rnd_p0;
    logic signed [OUT_W-1:0]  res_p0;
    logic                     sat_p0;
    logic                     vld_p0;

    logic signed [OUT_W-1:0]  mem [DEPTH];
    logic [PW-1:0]            wr_ptr, rd_ptr, rd_nxt;
    logic [LW-1:0]            level;
    logic signed [OUT_W-1:0]  head;
    logic                     full, do_pop, do_wr, drop;

    // Stage p0: group sum, rounding and saturation, all combinational on the last sample
    assign sum_p0 = acc + AW'(bus.in_data);
    assign vld_p0 = bus.in_valid && (cnt == CW'(DEC - 1));
    assign rnd_p0 = round_shift(sum_p0);
    assign res_p0 = sat_clip(rnd_p0);
    assign sat_p0 = is_sat(rnd_p0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            acc <= '0;
        end else if (bus.in_valid) begin
            if (vld_p0) begin
                cnt <= '0;
                acc <= '0;
            end else begin
                cnt <= cnt + CW'(1);
                acc <= sum_p0;
            end
        end
    end

    // FIFO: a full FIFO still accepts a push when a pop frees a slot in the same cycle
    assign full   = (level == LW'(DEPTH));
    assign do_pop = (level != '0) && bus.out_ready;
    assign do_wr  = vld_p0 && (!full || do_pop);
    assign drop   = vld_p0 && full && !do_pop;
    assign rd_nxt = rd_ptr + PW'(1);

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= res_p0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            head      <= '0;
            overflow  <= 1'b0;
            sat_event <= 1'b0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_nxt;
            level <= level + LW'(do_wr) - LW'(do_pop);
            // head register tracks the next FIFO head; holds its value when draining to empty
            if ((level - LW'(do_pop)) == '0) begin
                if (do_wr)
                    head <= res_p0;
            end else if (do_pop) begin
                head <= mem[rd_nxt];
            end
            overflow  <= drop | (overflow & ~clr_ovf);
            sat_event <= vld_p0 & sat_p0;
        end
    end

    assign bus.out_valid = (level != '0);
    assign bus.out_data  = head;
    assign fifo_level    = level;
endmodule

// File: tb/tb_fir_output_decimator.sv
// Directed bench for fir_output_decimator: queue-based reference model checked
// every cycle, plus hand-computed literal expectations.
module tb_fir_output_decimator;
    localparam int DEC   = 4;
    localparam int SHIFT = 2;
    localparam int OUT_W = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr_ovf = 1'b0;
    logic [$clog2(DEPTH):0] fifo_level;
    logic overflow, sat_event;

    int errors = 0;
    int checks = 0;

    fir_output_decimator_if #(.OUT_W(OUT_W)) bus ();

    fir_output_decimator #(.DEC(DEC), .SHIFT(SHIFT), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .sat_event  (sat_event),
        .clr_ovf    (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: group sum, spec rounding/clamp, result queue
    int  m_acc = 0;
    int  m_cnt = 0;
    int  m_q[$];
    bit  m_ovf = 0;
    bit  m_sat = 0;

    always @(negedge clk) begin
        int  sum, r;
        bit  push, pop, full, sat;
        if (rst) begin
            m_acc = 0; m_cnt = 0; m_q.delete(); m_ovf = 0; m_sat = 0;
        end
        check("out_valid", int'(bus.out_valid), int'(m_q.size() != 0));
        check("fifo_level", int'(fifo_level), m_q.size());
        check("overflow", int'(overflow), int'(m_ovf));
        check("sat_event", int'(sat_event), int'(m_sat));
        if (bus.out_valid && m_q.size() != 0)
            check("out_data", int'(bus.out_data), m_q[0]);
        if (!rst) begin
            push = 0; sat = 0; r = 0;
            if (bus.in_valid) begin
                sum = m_acc + int'(bus.in_data);
                if (m_cnt == DEC - 1) begin
                    push = 1;
                    r = (sum + ((SHIFT > 0) ? (1 << (SHIFT - 1)) : 0)) >>> SHIFT;
                    if (r > 2 ** (OUT_W - 1) - 1) begin r = 2 ** (OUT_W - 1) - 1; sat = 1; end
                    if (r < -(2 ** (OUT_W - 1))) begin r = -(2 ** (OUT_W - 1)); sat = 1; end
                    m_acc = 0; m_cnt = 0;
                end else begin
                    m_acc = sum; m_cnt++;
                end
            end
            full = (m_q.size() == DEPTH);
            pop  = (m_q.size() != 0) && bus.out_ready;
            if (pop) void'(m_q.pop_front());
            if (push && full && !pop) m_ovf = 1;
            else begin
                if (push) m_q.push_back(r);
                if (clr_ovf) m_ovf = 0;
            end
            m_sat = push && sat;
        end
    end

    task automatic send(input int v);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'(v);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic group4(input int a, input int b, input int c, input int d);
        send(a); send(b); send(c); send(d);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        idle(3);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_level", int'(fifo_level), 0);
        check("rst_out_data", int'(bus.out_data), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_sat", int'(sat_event), 0);
        rst = 1'b0;
        idle(2);

        group4(10, 20, 30, 40);
        check("basic_valid", int'(bus.out_valid), 1);
        check("basic_data", int'(bus.out_data), 25);
        check("basic_sat", int'(sat_event), 0);
        group4(-10, -10, -10, -10);
        check("neg_data", int'(bus.out_data), -10);
        group4(-3, -3, -2, -2);
        check("neg_tie", int'(bus.out_data), -2);
        group4(1000, 1000, 1000, 1000);
        check("sat_pos", int'(bus.out_data), 127);
        check("sat_pos_evt", int'(sat_event), 1);
        group4(-1000, -1000, -1000, -1000);
        check("sat_neg", int'(bus.out_data), -128);
        check("sat_neg_evt", int'(sat_event), 1);
        idle(2);

        for (int i = 1; i <= 4; i++) begin
            send(i);
            if (i < 4) check("gap_nopush", int'(bus.out_valid), 0);
            else check("gap_data", int'(bus.out_data), 3);
            idle(1);
        end
        idle(1);

        bus.out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) group4(k, k, k, k);
        check("bp_level", int'(fifo_level), 4);
        check("bp_overflow", int'(overflow), 1);
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("drain_data", int'(bus.out_data), k);
            idle(1);
        end
        check("drain_empty", int'(bus.out_valid), 0);
        clr_ovf = 1'b1; idle(1); clr_ovf = 1'b0;
        check("clr_ovf", int'(overflow), 0);

        bus.out_ready = 1'b0;
        for (int k = 6; k <= 9; k++) group4(k, k, k, k);
        send(10); send(10); send(10);
        bus.out_ready = 1'b1;
        send(10);
        bus.out_ready = 1'b0;
        check("pp_level", int'(fifo_level), 4);
        check("pp_overflow", int'(overflow), 0);
        check("pp_head", int'(bus.out_data), 7);
        send(11); send(11); send(11);
        clr_ovf = 1'b1;
        send(11);
        clr_ovf = 1'b0;
        check("set_wins", int'(overflow), 1);
        clr_ovf = 1'b1; idle(1); clr_ovf = 1'b0;
        check("clr_ovf2", int'(overflow), 0);
        bus.out_ready = 1'b1;
        idle(5);
        check("pp_drained", int'(fifo_level), 0);

        bus.out_ready = 1'b0;
        group4(5, 5, 5, 5);
        send(50); send(50);
        #2 rst = 1'b1;
        @(negedge clk); #1;
        check("mid_rst_valid", int'(bus.out_valid), 0);
        check("mid_rst_level", int'(fifo_level), 0);
        rst = 1'b0;
        idle(1);
        group4(4, 4, 4, 4);
        check("post_rst_data", int'(bus.out_data), 4);
        check("post_rst_level", int'(fifo_level), 1);
        bus.out_ready = 1'b1;
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
